// File: rtl/dht_read_scheduler_if.sv
// rtl/dht_read_scheduler_if.sv - request/response handshake bundle between decoder, scheduler and formatter
interface dht_read_scheduler_if;
  logic        req_valid;
  logic [2:0]  req_cmd;
  logic        req_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_cmd;
  logic [39:0] rsp_data;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        rsp_ready;

  // Requester side: issues commands and consumes responses
  modport master (
    output req_valid, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_cmd, rsp_data, rsp_error, rsp_timeout
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_cmd, rsp_data, rsp_error, rsp_timeout
  );
endinterface

// File: rtl/dht_read_scheduler.sv
// rtl/dht_read_scheduler.sv - sequences DHT11 reads with inter-read gap, timeout and continuous refresh
module dht_read_scheduler #(
  parameter int MIN_GAP     = 50_000_000,
  parameter int TIMEOUT     = 2_500_000,
  parameter int CONT_PERIOD = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dht_read_scheduler_if.slave    bus,
  output logic                   dht_start,
  input  logic                   dht_done,
  input  logic                   dht_error,
  input  logic [39:0]            dht_data,
  output logic                   cont_active
);

  localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int PW = (CONT_PERIOD > 2) ? $clog2(CONT_PERIOD) : 1;

  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [PW-1:0] PER_LAST = PW'(CONT_PERIOD - 1);
  localparam logic [PW-1:0] PER_ONE  = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP_WAIT,
    S_START,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t state, state_n;

  logic [GW-1:0] since_start;   // cycles elapsed since the last dht_start, saturating
  logic          gap_first;     // no read issued since reset, so no gap to honour
  logic [TW-1:0] tmo_cnt;       // cycles since dht_start of the read in flight
  logic [PW-1:0] per_cnt;
  logic          cont_pending;
  logic [2:0]    cont_cmd;
  logic [2:0]    cur_cmd;
  logic [2:0]    rsp_cmd_q;
  logic [39:0]   rsp_data_q;
  logic          rsp_error_q;
  logic          rsp_timeout_q;

  logic accept;
  logic take_pending;
  logic req_is_cont;
  logic gap_ok;

  assign accept       = (state == S_IDLE) && bus.req_valid;
  assign take_pending = (state == S_IDLE) && !bus.req_valid && cont_pending;
  assign req_is_cont  = (bus.req_cmd[2:1] == 2'b11);
  // START follows GAP_WAIT by one cycle, so release one cycle before the gap expires
  assign gap_ok       = gap_first || (since_start == GAP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (accept || take_pending) state_n = S_GAP_WAIT;
      S_GAP_WAIT:  if (gap_ok) state_n = S_START;
      S_START:     state_n = S_WAIT_DONE;
      S_WAIT_DONE: if (dht_done || (tmo_cnt == TMO_LAST)) state_n = S_RESPOND;
      S_RESPOND:   if (bus.rsp_ready) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Outputs; handshake strobes are masked while reset is held so nothing leaks out
  always_comb begin
    bus.req_ready   = rst_n && (state == S_IDLE);
    dht_start       = rst_n && (state == S_START);
    bus.rsp_valid   = rst_n && (state == S_RESPOND);
    bus.rsp_cmd     = rsp_cmd_q;
    bus.rsp_data    = rsp_data_q;
    bus.rsp_error   = rsp_error_q;
    bus.rsp_timeout = rsp_timeout_q;
  end

  // Gap/timeout/period counters, continuous-mode bookkeeping and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      since_start   <= '0;
      gap_first     <= 1'b1;
      tmo_cnt       <= '0;
      per_cnt       <= '0;
      cont_active   <= 1'b0;
      cont_pending  <= 1'b0;
      cont_cmd      <= '0;
      cur_cmd       <= '0;
      rsp_cmd_q     <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state == S_START) begin
        since_start <= GAP_ONE;
        gap_first   <= 1'b0;
      end else if (since_start != GAP_LAST) begin
        since_start <= since_start + GAP_ONE;
      end

      if ((state == S_START) || (state == S_WAIT_DONE)) tmo_cnt <= tmo_cnt + TMO_ONE;
      else                                               tmo_cnt <= '0;

      // Consume an old tick first so a tick landing this cycle is not lost
      if (take_pending) begin
        cur_cmd      <= cont_cmd;
        cont_pending <= 1'b0;
      end

      if (accept && req_is_cont) begin
        per_cnt <= '0;
      end else if (cont_active) begin
        if (per_cnt == PER_LAST) begin
          per_cnt      <= '0;
          cont_pending <= 1'b1;
        end else begin
          per_cnt <= per_cnt + PER_ONE;
        end
      end

      // External request wins over a pending tick; a non-continuous one ends the mode
      if (accept) begin
        cur_cmd <= bus.req_cmd;
        if (req_is_cont) begin
          cont_active <= 1'b1;
          cont_cmd    <= bus.req_cmd;
        end else begin
          cont_active  <= 1'b0;
          cont_pending <= 1'b0;
        end
      end

      if (state == S_WAIT_DONE) begin
        if (dht_done) begin
          rsp_cmd_q     <= cur_cmd;
          rsp_data_q    <= dht_data;
          rsp_error_q   <= dht_error;
          rsp_timeout_q <= 1'b0;
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_cmd_q     <= cur_cmd;
          rsp_data_q    <= '0;
          rsp_error_q   <= 1'b1;
          rsp_timeout_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht_read_scheduler.sv
// tb/tb_dht_read_scheduler.sv - self-checking bench for dht_read_scheduler
module tb_dht_read_scheduler;
  localparam int MIN_GAP = 20;
  localparam int TIMEOUT = 50;
  localparam int PERIOD  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dht_start;
  logic        dht_done = 1'b0;
  logic        dht_error;
  logic [39:0] dht_data;
  logic        cont_active;

  dht_read_scheduler_if bus();

  dht_read_scheduler #(
    .MIN_GAP(MIN_GAP),
    .TIMEOUT(TIMEOUT),
    .CONT_PERIOD(PERIOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dht_start(dht_start),
    .dht_done(dht_done),
    .dht_error(dht_error),
    .dht_data(dht_data),
    .cont_active(cont_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait expired before the expected event (cycle %0d)", nm, cyc);
  endfunction

  // Fake DHT11 driver: answers drv_lat cycles after each start (never if drv_lat < 0)
  int          drv_lat = -1;
  int          drv_done_at = -1;
  logic [39:0] drv_data = '0;
  logic        drv_err = 1'b0;
  logic        extra_done = 1'b0;
  assign dht_data  = drv_data;
  assign dht_error = drv_err;

  always @(negedge clk) if (dht_start === 1'b1 && drv_lat >= 0) drv_done_at = cyc + drv_lat;
  always @(posedge clk) begin
    #2;
    dht_done = (cyc == drv_done_at) || extra_done;
  end

  // Observation of what the DUT did, for the directed literal checks
  int          start_count = 0, last_start = 0, prev_start = 0;
  int          rsp_count = 0, rsp_first = 0;
  logic        rsp_prev = 1'b0;
  logic [2:0]  cap_cmd;
  logic [39:0] cap_data;
  logic        cap_err, cap_tmo;

  always @(negedge clk) begin
    if (dht_start === 1'b1) begin
      prev_start = last_start;
      last_start = cyc;
      start_count++;
    end
    if (bus.rsp_valid === 1'b1 && !rsp_prev) begin
      rsp_first = cyc;
      cap_cmd   = bus.rsp_cmd;
      cap_data  = bus.rsp_data;
      cap_err   = bus.rsp_error;
      cap_tmo   = bus.rsp_timeout;
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) rsp_count++;
    rsp_prev = (bus.rsp_valid === 1'b1);
  end

  // Timestamp model: a read begun at cycle c starts at max(c+2, last_start+MIN_GAP),
  // answers the cycle after the driver's done, or TIMEOUT cycles after start;
  // continuous ticks fall every PERIOD cycles after the continuous command.
  bit          m_busy = 0, m_first = 1, m_cont = 0, m_pend = 0;
  int          m_start = -1, m_rsp = -1, m_last = 0, m_base = 0;
  logic [2:0]  m_cmd = '0, m_ccmd = '0;
  logic [39:0] m_data = '0;
  logic        m_err = 1'b0, m_tmo = 1'b0;
  bit          e_rv, idle, tick;

  function automatic void begin_read(input logic [2:0] cmd);
    int s;
    s = cyc + 2;
    if (!m_first && (m_last + MIN_GAP > s)) s = m_last + MIN_GAP;
    m_busy  = 1;
    m_cmd   = cmd;
    m_start = s;
    m_rsp   = -1;
  endfunction

  always @(negedge clk) begin
    e_rv = rst_n && m_busy && (m_rsp >= 0) && (cyc >= m_rsp);
    chk("req_ready", bus.req_ready, rst_n && !m_busy);
    chk("dht_start", dht_start, rst_n && (cyc == m_start));
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("cont_active", cont_active, m_cont);
    if (e_rv) begin
      chk("rsp_cmd", bus.rsp_cmd, m_cmd);
      chk("rsp_data", bus.rsp_data, m_data);
      chk("rsp_error", bus.rsp_error, m_err);
      chk("rsp_timeout", bus.rsp_timeout, m_tmo);
    end
    if (!rst_n) begin
      m_busy = 0; m_first = 1; m_cont = 0; m_pend = 0;
      m_start = -1; m_rsp = -1;
    end else begin
      idle = !m_busy;
      if (m_start >= 0 && m_rsp < 0 && cyc > m_start) begin
        if (dht_done) begin
          m_rsp = cyc + 1; m_data = dht_data; m_err = dht_error; m_tmo = 1'b0;
        end else if (cyc == m_start + TIMEOUT - 1) begin
          m_rsp = cyc + 1; m_data = '0; m_err = 1'b1; m_tmo = 1'b1;
        end
      end
      if (cyc == m_start) begin
        m_last  = cyc;
        m_first = 0;
      end
      if (e_rv && bus.rsp_ready) begin
        m_busy = 0; m_start = -1; m_rsp = -1;
      end
      tick = m_cont && (((cyc - m_base) % PERIOD) == PERIOD - 1);
      if (idle && bus.req_valid) begin
        begin_read(bus.req_cmd);
        if (bus.req_cmd[2:1] == 2'b11) begin
          m_cont = 1; m_ccmd = bus.req_cmd; m_base = cyc + 1; tick = 0;
        end else begin
          m_cont = 0; m_pend = 0; tick = 0;
        end
      end else if (idle && m_pend) begin
        begin_read(m_ccmd);
        m_pend = 0;
      end
      if (tick) m_pend = 1;
    end
  end

  // Stimulus helpers
  int acc_cyc = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] cmd);
    bit got;
    got = 0;
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        got = 1;
        break;
      end
      @(posedge clk);
    end
    if (!got) fail("req_accept_wait");
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit rand_ready);
    bit got;
    got = 0;
    for (int i = 0; i < 500; i++) begin
      if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) fail("rsp_wait");
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  cmds [3] = '{3'd0, 3'd1, 3'd3};
  logic [63:0] rnd;
  int          n0, rc;
  bit          seen;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    step(3);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_cont_active", cont_active, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    rst_n = 1'b1;
    step(1);
    chk("idle_req_ready", bus.req_ready, 1);

    // Single read with data
    drv_lat = 10; drv_data = 40'h3A00190053; drv_err = 1'b0;
    send_req(3'b001);
    wait_rsp(0);
    chk("t1_start_latency", last_start - acc_cyc, 2);
    chk("t1_rsp_latency", rsp_first - last_start, 11);
    chk("t1_rsp_cmd", cap_cmd, 3'b001);
    chk("t1_rsp_data", cap_data, 40'h3A00190053);
    chk("t1_rsp_error", cap_err, 0);
    chk("t1_start_count", start_count, 1);

    // Back-to-back reads honour the gap
    drv_lat = 3; drv_data = 40'h1122334455;
    send_req(3'b011);
    wait_rsp(0);
    send_req(3'b011);
    wait_rsp(0);
    chk("t2_gap", last_start - prev_start, MIN_GAP);

    // Driver never answers
    drv_lat = -1;
    send_req(3'b001);
    wait_rsp(0);
    chk("t3_timeout_latency", rsp_first - last_start, TIMEOUT);
    chk("t3_rsp_timeout", cap_tmo, 1);
    chk("t3_rsp_error", cap_err, 1);
    chk("t3_rsp_data", cap_data, 0);

    // Continuous mode
    drv_lat = 5; drv_data = 40'h2A00170042;
    send_req(3'b110);
    chk("t4_cont_on", cont_active, 1);
    n0 = start_count;
    for (int i = 0; i < 600 && start_count < n0 + 4; i++) step(1);
    if (start_count < n0 + 4) fail("t4_self_reads");
    chk("t4_period", last_start - prev_start, PERIOD);
    chk("t4_rsp_cmd", cap_cmd, 3'b110);
    send_req(3'b001);
    wait_rsp(0);
    chk("t4_cont_off", cont_active, 0);
    n0 = start_count;
    step(250);
    chk("t4_no_self_reads", start_count, n0);

    // Formatter stalls
    bus.rsp_ready = 1'b0;
    drv_lat = 4; drv_data = 40'h0102030405;
    n0 = start_count;
    send_req(3'b011);
    step(40);
    chk("t5_hold_valid", bus.rsp_valid, 1);
    chk("t5_hold_req_ready", bus.req_ready, 0);
    chk("t5_hold_cmd", bus.rsp_cmd, 3'b011);
    chk("t5_hold_data", bus.rsp_data, 40'h0102030405);
    chk("t5_single_start", start_count, n0 + 1);
    bus.rsp_ready = 1'b1;
    wait_rsp(0);
    step(2);
    rc = rsp_count;
    extra_done = 1'b1;
    step(1);
    extra_done = 1'b0;
    step(5);
    chk("t5_idle_done_ignored", rsp_count, rc);

    // Reset during WAIT_DONE
    drv_lat = 30;
    n0 = start_count;
    send_req(3'b001);
    for (int i = 0; i < 100 && start_count == n0; i++) step(1);
    if (start_count == n0) fail("t6_start_wait");
    step(5);
    rst_n = 1'b0;
    step(1);
    chk("t6_rst_req_ready", bus.req_ready, 0);
    chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t6_rst_dht_start", dht_start, 0);
    chk("t6_rst_rsp_data", bus.rsp_data, 0);
    rst_n = 1'b1;
    rc = rsp_count;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    chk("t6_no_response", seen, 0);
    chk("t6_rsp_count", rsp_count, rc);

    // Randomised reads with random latency, errors and formatter stalls
    for (int k = 0; k < 25; k++) begin
      drv_lat  = $urandom_range(1, 60);
      rnd      = {$urandom, $urandom};
      drv_data = rnd[39:0];
      drv_err  = 1'($urandom_range(0, 1));
      send_req(cmds[$urandom_range(0, 2)]);
      wait_rsp(1);
      step($urandom_range(0, 30));
    end

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
